l2_ram_banked_init: RTL and testbench
=====================================

# l2_ram_banked_init

Parametrised multi-bank L2 SRAM model: one word-addressed request port, NB_BANKS behavioural banks in either contiguous or word-interleaved address mapping, byte-enabled writes, configurable read latency, and a hardware initialisation sweeper. It sits behind the SoC L2 interconnect as the next-generation generic L2 memory. It replaces per-bank hard-coded cuts with one parametrised array whose contents have a defined state after boot.

## Interface
- NB_BANKS, 4: number of banks; power of two, >= 1
- BANK_WORDS, 8192: words per bank; power of two, >= 2
- DATA_WIDTH, 32: word width; multiple of 8
- INTERLEAVED, 1: 1 = bank = addr[log2(NB_BANKS)-1:0]; 0 = bank = addr MSBs (contiguous)
- READ_PIPE, 0: 0 = read latency 1 cycle; 1 = extra output register, latency 2
- INIT_ON_RESET, 1: 1 = sweep starts automatically after reset release
- INIT_VALUE, 0: DATA_WIDTH-bit value written by the sweep
- ADDR_WIDTH (derived): log2(NB_BANKS*BANK_WORDS)
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- init_req_i  in  1  pulse: start an initialisation sweep
- init_done_o  out  1  high when the sweep has completed and the port is usable
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  word address
- be_i  in  DATA_WIDTH/8  byte enables (writes only)
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  read data valid
- rdata_o  out  DATA_WIDTH  read data

## Operation
- FSM states: IDLE, INIT. Reset value: INIT if INIT_ON_RESET=1, else IDLE.
- INIT: counter idx runs 0..BANK_WORDS-1, one step per cycle. Each step writes INIT_VALUE to word idx of every bank in parallel. At idx = BANK_WORDS-1: go to IDLE, set init_done_o. Counter resets to 0 on exit.
- IDLE: gnt_o = req_i & ~init_req_i (combinational). init_req_i in IDLE has priority over a same-cycle req_i: no grant; next state INIT; init_done_o cleared next cycle.
- init_req_i in INIT is ignored; the sweep is not restarted.
- gnt_o = 0 throughout INIT. req_i held across INIT is granted in the first IDLE cycle.
- Granted write: bank/row decode per INTERLEAVED; only bytes with be_i=1 are updated; be_i=0 gives no write; no rvalid_o.
- Granted read: the addressed word is launched; rvalid_o/rdata_o follow per Timing. A read granted in the cycle before INIT begins still completes with its pre-sweep data.
- Decode: INTERLEAVED=1: bank = addr_i[log2(NB_BANKS)-1:0], row = remaining upper bits. INTERLEAVED=0: bank = upper log2(NB_BANKS) bits, row = lower log2(BANK_WORDS) bits. NB_BANKS=1 ignores the bank field.
- Memory contents are not affected by rst_i. Only the sweep or writes change them.

## Timing
- Reset outputs: gnt_o combinational (0 while state INIT or req_i=0), init_done_o=0, rvalid_o=0, rdata_o=0.
- Reset asserted mid-sweep or mid-read: counter, FSM and the read pipeline clear immediately. Pending rvalid is dropped. On release, behaviour follows INIT_ON_RESET.
- Sweep duration: BANK_WORDS cycles from the first INIT cycle. init_done_o rises on the clock edge that enters IDLE.
- Read latency: a grant at edge N gives rvalid_o=1 for exactly one cycle after edge N+1 (READ_PIPE=0) or N+2 (READ_PIPE=1). Back-to-back reads give back-to-back rvalid_o. Throughput is one access per cycle.
- rdata_o holds its last value when rvalid_o=0.
- Read-after-write: a write granted at N followed by a read of the same address at N+1 returns the new data.

## Test plan
- NB_BANKS=4, BANK_WORDS=16, INIT_ON_RESET=1, INIT_VALUE=32'hDEADBEEF; release reset, hold req_i -> gnt_o=0 for 16 cycles; init_done_o=1 on the 16th edge; read of every address 0..63 returns DEADBEEF.
- INTERLEAVED=1: write addr 0..7 with data = addr, be=4'hF, then read back -> correct data. Internal probe: addresses 0,4 land in bank 0 rows 0,1. Repeat with INTERLEAVED=0 -> addresses 0..7 land in bank 0 rows 0..7.
- Partial write: write 32'h11223344 be=4'hF, then 32'hAABBCCDD be=4'b0101 to the same address -> read returns 32'h11BB33DD.
- READ_PIPE=1: reads at consecutive cycles to addresses 3,5,7 -> rvalid_o high on the 2nd, 3rd and 4th edges after the first grant, data in order.
- init_req_i with req_i in the same IDLE cycle -> gnt_o=0 that cycle; INIT lasts BANK_WORDS cycles; request granted on the first IDLE cycle. A second init_req_i pulse mid-sweep does not extend the sweep.
- Assert rst_i at sweep step 7 -> init_done_o=0 and rvalid_o=0 immediately. After release a full sweep restarts from idx 0.

Source files
------------

// File: rtl/l2_ram_banked_init.sv
// Parametrised multi-bank L2 SRAM model with byte-enabled writes, 1- or 2-cycle read
// latency and a hardware sweep that writes INIT_VALUE to every word after boot.
module l2_ram_banked_init #(
    parameter int unsigned           NB_BANKS      = 4,
    parameter int unsigned           BANK_WORDS    = 8192,
    parameter int unsigned           DATA_WIDTH    = 32,
    parameter bit                    INTERLEAVED   = 1'b1,
    parameter bit                    READ_PIPE     = 1'b0,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    localparam int unsigned          BANK_BITS     = $clog2(NB_BANKS),
    localparam int unsigned          ROW_BITS      = $clog2(BANK_WORDS),
    localparam int unsigned          ADDR_WIDTH    = BANK_BITS + ROW_BITS,
    localparam int unsigned          BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_req_i,
    output logic                  init_done_o,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned BANK_IDX_W = (BANK_BITS == 0) ? 1 : BANK_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ROW_BITS-1:0]   idx_q, idx_d;
    logic                  init_done_q, init_done_d;
    logic                  sweep_en;
    logic                  wr_en, rd_en;
    logic [BANK_IDX_W-1:0] bank_idx;
    logic [ROW_BITS-1:0]   row_idx;

    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic [DATA_WIDTH-1:0] mem [NB_BANKS][BANK_WORDS];

    // Address decode: low bits select the bank when interleaved, high bits otherwise.
    if (NB_BANKS == 1) begin : g_single_bank
        assign bank_idx = '0;
        assign row_idx  = addr_i[ROW_BITS-1:0];
    end else if (INTERLEAVED) begin : g_interleaved
        assign bank_idx = addr_i[BANK_BITS-1:0];
        assign row_idx  = addr_i[ADDR_WIDTH-1:BANK_BITS];
    end else begin : g_contiguous
        assign bank_idx = addr_i[ADDR_WIDTH-1:ROW_BITS];
        assign row_idx  = addr_i[ROW_BITS-1:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        gnt_o       = 1'b0;
        sweep_en    = 1'b0;
        case (state_q)
            IDLE: begin
                // A same-cycle sweep request wins over the access port.
                if (init_req_i) begin
                    state_d     = INIT;
                    init_done_d = 1'b0;
                end else begin
                    gnt_o = req_i;
                end
            end
            INIT: begin
                sweep_en = 1'b1;
                if (idx_q == ROW_BITS'(BANK_WORDS - 1)) begin
                    state_d     = IDLE;
                    idx_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + ROW_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en = gnt_o & we_i;
    assign rd_en = gnt_o & ~we_i;

    always_comb begin
        rvalid1_d = rd_en;
        rdata1_d  = rd_en ? mem[bank_idx][row_idx] : rdata1_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= INIT_ON_RESET ? INIT : IDLE;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rvalid1_q   <= rvalid1_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // NOTE: the array has no reset; its contents are defined only by the sweep or by writes.
    always_ff @(posedge clk_i) begin
        if (sweep_en) begin
            for (int unsigned b = 0; b < NB_BANKS; b++) begin
                mem[b][idx_q] <= INIT_VALUE;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (be_i[i]) begin
                    mem[bank_idx][row_idx][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    if (READ_PIPE) begin : g_read_pipe
        logic                  rvalid2_q, rvalid2_d;
        logic [DATA_WIDTH-1:0] rdata2_q, rdata2_d;

        always_comb begin
            rvalid2_d = rvalid1_q;
            rdata2_d  = rvalid1_q ? rdata1_q : rdata2_q;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rvalid2_q <= 1'b0;
                rdata2_q  <= '0;
            end else begin
                rvalid2_q <= rvalid2_d;
                rdata2_q  <= rdata2_d;
            end
        end

        assign rvalid_o = rvalid2_q;
        assign rdata_o  = rdata2_q;
    end else begin : g_read_direct
        assign rvalid_o = rvalid1_q;
        assign rdata_o  = rdata1_q;
    end

    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_l2_ram_banked_init.sv
// Drives one stimulus stream into an interleaved 1-cycle instance and a contiguous
// 2-cycle instance; a shared reference model feeds per-instance read scoreboards.
module tb_l2_ram_banked_init;

    localparam int          NB = 4;
    localparam int          BW = 16;
    localparam int          AW = 6;
    localparam int          NW = NB * BW;
    localparam logic [31:0] IV = 32'hDEADBEEF;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_req = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [3:0]    be = '0;
    logic [31:0]   wdata = '0;

    logic        done_a, gnt_a, rvalid_a;
    logic [31:0] rdata_a;
    logic        done_b, gnt_b, rvalid_b;
    logic [31:0] rdata_b;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic [31:0] model [NW];
    exp_t        q_a [$];
    exp_t        q_b [$];
    exp_t        e_mon;

    l2_ram_banked_init #(
        .NB_BANKS(NB), .BANK_WORDS(BW), .DATA_WIDTH(32), .INTERLEAVED(1'b1),
        .READ_PIPE(1'b0), .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .init_done_o(done_a),
        .req_i(req), .gnt_o(gnt_a), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a)
    );

    l2_ram_banked_init #(
        .NB_BANKS(NB), .BANK_WORDS(BW), .DATA_WIDTH(32), .INTERLEAVED(1'b0),
        .READ_PIPE(1'b1), .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .init_req_i(init_req), .init_done_o(done_b),
        .req_i(req), .gnt_o(gnt_b), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: accepted reads are queued with their due cycle; returns are popped here.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0)
                $display("FAIL reset_rvalid: a=%b b=%b required 0", rvalid_a, rvalid_b);
            else
                passes++;
            q_a.delete();
            q_b.delete();
        end else begin
            if (rvalid_a === 1'b1) begin
                checks++;
                if (q_a.size() == 0) begin
                    $display("FAIL rd_a_unexpected: rvalid at cycle %0d data %h, none required", cyc, rdata_a);
                end else begin
                    e_mon = q_a.pop_front();
                    if (rdata_a !== e_mon.data || cyc != e_mon.due)
                        $display("FAIL rd_a: data %h cycle %0d, required %h cycle %0d",
                                 rdata_a, cyc, e_mon.data, e_mon.due);
                    else
                        passes++;
                end
            end else if (q_a.size() != 0 && q_a[0].due <= cyc) begin
                checks++;
                $display("FAIL rd_a_missing: no rvalid at cycle %0d, required data %h", cyc, q_a[0].data);
                void'(q_a.pop_front());
            end
            if (rvalid_b === 1'b1) begin
                checks++;
                if (q_b.size() == 0) begin
                    $display("FAIL rd_b_unexpected: rvalid at cycle %0d data %h, none required", cyc, rdata_b);
                end else begin
                    e_mon = q_b.pop_front();
                    if (rdata_b !== e_mon.data || cyc != e_mon.due)
                        $display("FAIL rd_b: data %h cycle %0d, required %h cycle %0d",
                                 rdata_b, cyc, e_mon.data, e_mon.due);
                    else
                        passes++;
                end
            end else if (q_b.size() != 0 && q_b[0].due <= cyc) begin
                checks++;
                $display("FAIL rd_b_missing: no rvalid at cycle %0d, required data %h", cyc, q_b[0].data);
                void'(q_b.pop_front());
            end
            if (req === 1'b1 && gnt_a === 1'b1) begin
                if (we) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) model[addr][i*8 +: 8] = wdata[i*8 +: 8];
                end else begin
                    q_a.push_back('{data: model[addr], due: cyc + 1});
                    q_b.push_back('{data: model[addr], due: cyc + 2});
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [3:0] b, input logic [31:0] d, input logic ir);
        @(posedge clk);
        #1;
        req      = r;
        we       = w;
        addr     = a;
        be       = b;
        wdata    = d;
        init_req = ir;
    endtask

    task automatic fill_model();
        for (int i = 0; i < NW; i++) model[i] = IV;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 8 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0)
            $display("FAIL %s_drain: pending reads a=%0d b=%0d, required 0", name, q_a.size(), q_b.size());
        else
            passes++;
    endtask

    // Expects reset just released with a read request held: BW blocked cycles, then grant.
    task automatic check_full_sweep(input string name);
        for (int i = 0; i < BW; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt_a, gnt_b, done_a, done_b} !== 4'b0000)
                $display("FAIL %s_busy: step %0d gnt/done=%b, required 0000", name, i,
                         {gnt_a, gnt_b, done_a, done_b});
            else
                passes++;
        end
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, done_a, done_b} !== 4'b1111)
            $display("FAIL %s_end: gnt/done=%b, required 1111", name, {gnt_a, gnt_b, done_a, done_b});
        else
            passes++;
    endtask

    task automatic test_reset();
        req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({done_a, done_b, gnt_a, gnt_b, rvalid_a, rvalid_b} !== 6'b0)
            $display("FAIL reset_ctrl: done/gnt/rvalid=%b, required 000000",
                     {done_a, done_b, gnt_a, gnt_b, rvalid_a, rvalid_b});
        else
            passes++;
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0)
            $display("FAIL reset_rdata: a=%h b=%h, required 0", rdata_a, rdata_b);
        else
            passes++;
    endtask

    task automatic test_init_sweep();
        fill_model();
        req  = 1'b1;
        we   = 1'b0;
        addr = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        check_full_sweep("boot_sweep");
        for (int a = 0; a < NW; a++) drive(1'b1, 1'b0, AW'(a), 4'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0);
        wait_drain("boot_readback");
    endtask

    task automatic test_mapping();
        for (int a = 0; a < 8; a++) drive(1'b1, 1'b1, AW'(a), 4'hF, 32'(a), 1'b0);
        for (int a = 0; a < 8; a++) drive(1'b1, 1'b0, AW'(a), 4'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0);
        wait_drain("mapping");
        checks++;
        if (dut_a.mem[0][0] !== 32'd0 || dut_a.mem[0][1] !== 32'd4 ||
            dut_a.mem[1][0] !== 32'd1 || dut_a.mem[3][1] !== 32'd7)
            $display("FAIL map_interleaved: b0r0=%h b0r1=%h b1r0=%h b3r1=%h, required 0 4 1 7",
                     dut_a.mem[0][0], dut_a.mem[0][1], dut_a.mem[1][0], dut_a.mem[3][1]);
        else
            passes++;
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (dut_b.mem[0][r] !== 32'(r))
                $display("FAIL map_contiguous: bank0 row %0d=%h, required %h", r, dut_b.mem[0][r], 32'(r));
            else
                passes++;
        end
        checks++;
        if (dut_b.mem[1][0] !== IV)
            $display("FAIL map_contiguous_b1: bank1 row0=%h, required %h", dut_b.mem[1][0], IV);
        else
            passes++;
    endtask

    task automatic test_partial_write();
        drive(1'b1, 1'b1, 6'd9, 4'hF, 32'h11223344, 1'b0);
        drive(1'b1, 1'b1, 6'd9, 4'b0101, 32'hAABBCCDD, 1'b0);
        drive(1'b1, 1'b0, 6'd9, 4'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 6'd9, 4'h0, 32'hFFFFFFFF, 1'b0);
        drive(1'b1, 1'b0, 6'd9, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0);
        wait_drain("partial");
        checks++;
        if (rdata_a !== 32'h11BB33DD || rdata_b !== 32'h11BB33DD)
            $display("FAIL partial_merge: a=%h b=%h, required 11bb33dd", rdata_a, rdata_b);
        else
            passes++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 6'd3, 4'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 6'd5, 4'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 6'd7, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0);
        wait_drain("b2b");
        @(negedge clk);
        checks++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || rdata_a !== 32'd7 || rdata_b !== 32'd7)
            $display("FAIL rdata_hold: rvalid %b%b data a=%h b=%h, required 00 and 7",
                     rvalid_a, rvalid_b, rdata_a, rdata_b);
        else
            passes++;
    endtask

    task automatic test_init_req();
        drive(1'b1, 1'b0, 6'd6, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b} !== 2'b11)
            $display("FAIL pre_sweep_read_gnt: gnt=%b, required 11", {gnt_a, gnt_b});
        else
            passes++;
        drive(1'b1, 1'b0, 6'd5, 4'h0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, done_a, done_b} !== 4'b0011)
            $display("FAIL init_req_priority: gnt/done=%b, required 0011", {gnt_a, gnt_b, done_a, done_b});
        else
            passes++;
        for (int k = 1; k <= BW; k++) begin
            drive(1'b1, 1'b0, 6'd5, 4'h0, 32'h0, (k == 5));
            if (k == 1) fill_model();
            @(negedge clk);
            checks++;
            if ({gnt_a, gnt_b, done_a, done_b} !== 4'b0000)
                $display("FAIL init_req_busy: step %0d gnt/done=%b, required 0000", k,
                         {gnt_a, gnt_b, done_a, done_b});
            else
                passes++;
        end
        drive(1'b1, 1'b0, 6'd5, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, done_a, done_b} !== 4'b1111)
            $display("FAIL init_req_end: gnt/done=%b, required 1111", {gnt_a, gnt_b, done_a, done_b});
        else
            passes++;
        drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0);
        wait_drain("init_req");
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 6'd2, 4'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1 req = 1'b0;
        checks++;
        if (rvalid_a !== 1'b1 || rdata_a !== model[2])
            $display("FAIL mid_read_launch: rvalid=%b data=%h, required 1 %h", rvalid_a, rdata_a, model[2]);
        else
            passes++;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({done_a, done_b, rvalid_a, rvalid_b, gnt_a, gnt_b} !== 6'b0)
            $display("FAIL mid_read_reset: done/rvalid/gnt=%b, required 000000",
                     {done_a, done_b, rvalid_a, rvalid_b, gnt_a, gnt_b});
        else
            passes++;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req  = 1'b1;
        addr = '0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({done_a, done_b, rvalid_a, rvalid_b, gnt_a, gnt_b} !== 6'b0)
            $display("FAIL mid_sweep_reset: done/rvalid/gnt=%b, required 000000",
                     {done_a, done_b, rvalid_a, rvalid_b, gnt_a, gnt_b});
        else
            passes++;
        @(posedge clk);
        #1 rst = 1'b0;
        check_full_sweep("restart_sweep");
        drive(1'b1, 1'b0, 6'd63, 4'h0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 6'd20, 4'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, '0, 4'h0, 32'h0, 1'b0);
        wait_drain("restart_readback");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, required finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_init_sweep();
        test_mapping();
        test_partial_write();
        test_back_to_back();
        test_init_req();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
